// File: rtl/instr_sequencer.sv
// instr_sequencer: program fetch / sequencing front end of the Forth stack CPU.
//
// Reads 20-bit instruction words from a synchronous instruction memory.
// Words are prefetched into a small FIFO.
//   - JMP and HALT are executed locally at the FIFO head.
//   - Undefined opcodes are dropped at the head and raise a sticky flag.
//   - Data-path opcodes are handed to control_unit through a registered
//     valid/ready output stage.
//
// Optional feature macro: SEQ_JZ_EN.
//   - When defined, opcode 8 is JZ (conditional jump on tos_zero).
//   - When undefined, opcode 8 is treated as undefined.
module instr_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [19:0]       imem_data,
    output logic [3:0]        command,
    output logic [15:0]       literal,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              tos_zero,
    output logic              halted,
    output logic              illegal
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DUP  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;
`ifdef SEQ_JZ_EN
    localparam logic [3:0] OP_JZ   = 4'd8;
`endif

    // What the FIFO head does this cycle.
    typedef enum logic [2:0] {
        ACT_NONE,   // FIFO empty
        ACT_STALL,  // head must wait (output stage busy or JZ settling)
        ACT_FWD,    // head moves into the output register
        ACT_JMP,    // redirect: pc <= target, flush prefetch
        ACT_HALT,   // stop fetching for good, flush prefetch
        ACT_DROP,   // head retired silently (JZ not taken)
        ACT_ILL     // undefined opcode retired, flag raised
    } head_act_e;

    // Program counter and read tracking
    logic [ADDR_W-1:0] pc_r;
    logic              inflight_r;

    // Prefetch FIFO
    logic [19:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Output stage and status
    logic              cmd_valid_r;
    logic [3:0]        command_r;
    logic [15:0]       literal_r;
    logic              halted_r;
    logic              illegal_r;

    // Combinational control
    logic              head_valid_s;
    logic [19:0]       head_word_s;
    logic [3:0]        head_op_s;
    logic [ADDR_W-1:0] target_s;
    logic              load_ok_s;
    head_act_e         act_s;
    logic              pop_s;
    logic              flush_s;
    logic              push_s;
    logic              fetch_s;
    logic [OCC_W-1:0]  occ_s;
    logic [OCC_W-1:0]  lim_s;

`ifdef SEQ_JZ_EN
    logic              idle_q_r;
`else
    logic              unused_tos_zero_s;
    assign unused_tos_zero_s = tos_zero;
`endif

    assign head_valid_s = (count_r != {CNT_W{1'b0}});
    assign head_word_s  = fifo_mem_r[rd_ptr_r];
    assign head_op_s    = head_word_s[19:16];
    assign target_s     = head_word_s[ADDR_W-1:0];
    assign load_ok_s    = !cmd_valid_r || cmd_ready;

    // Decode the FIFO head into the action it takes this cycle.
    always_comb begin
        act_s = ACT_NONE;
        if (head_valid_s) begin
            case (head_op_s)
                OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_MUL, OP_DUP: begin
                    if (load_ok_s) begin
                        act_s = ACT_FWD;
                    end else begin
                        act_s = ACT_STALL;
                    end
                end
                OP_JMP:  act_s = ACT_JMP;
                OP_HALT: act_s = ACT_HALT;
`ifdef SEQ_JZ_EN
                OP_JZ: begin
                    // Only decide once the output stage has been empty for a
                    // full cycle, so tos_zero reflects every accepted command.
                    if (!cmd_valid_r && idle_q_r) begin
                        if (tos_zero) begin
                            act_s = ACT_JMP;
                        end else begin
                            act_s = ACT_DROP;
                        end
                    end else begin
                        act_s = ACT_STALL;
                    end
                end
`endif
                default: act_s = ACT_ILL;
            endcase
        end else begin
            act_s = ACT_NONE;
        end
    end

    assign pop_s   = (act_s == ACT_FWD) || (act_s == ACT_DROP) || (act_s == ACT_ILL);
    assign flush_s = (act_s == ACT_JMP) || (act_s == ACT_HALT);
    // A response arriving in the same cycle as a redirect/halt is discarded.
    assign push_s  = inflight_r && !flush_s;

    // Occupancy counts the in-flight read; a head retiring this cycle frees a
    // slot so the fetch stream can sustain one instruction per cycle.
    assign occ_s = OCC_W'(count_r) + OCC_W'(inflight_r);
    assign lim_s = OCC_W'(FIFO_DEPTH) + OCC_W'(pop_s);

    // Fetch issue decision.
    always_comb begin
        fetch_s = 1'b0;
        if (rst) begin
            fetch_s = 1'b0;
        end else if (halted_r || (act_s == ACT_HALT)) begin
            fetch_s = 1'b0;
        end else begin
            fetch_s = (occ_s < lim_s);
        end
    end

    assign imem_rd   = fetch_s;
    assign imem_addr = pc_r;

    // Program counter and in-flight read flag; a redirect overrides the increment
    // and kills any read issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= ADDR_W'(RESET_PC);
            inflight_r <= 1'b0;
        end else if (act_s == ACT_JMP) begin
            pc_r       <= target_s;
            inflight_r <= 1'b0;
        end else if (act_s == ACT_HALT) begin
            pc_r       <= pc_r;
            inflight_r <= 1'b0;
        end else if (fetch_s) begin
            pc_r       <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            inflight_r <= 1'b1;
        end else begin
            pc_r       <= pc_r;
            inflight_r <= 1'b0;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= imem_data;
        end
    end

    // FIFO pointers and occupancy; flushed on reset, JMP and HALT.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Output stage: load a forwarded opcode, clear after transfer, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r <= 1'b0;
            command_r   <= 4'd0;
            literal_r   <= 16'd0;
        end else if (act_s == ACT_FWD) begin
            cmd_valid_r <= 1'b1;
            command_r   <= head_op_s;
            literal_r   <= head_word_s[15:0];
        end else if (cmd_valid_r && cmd_ready) begin
            cmd_valid_r <= 1'b0;
            command_r   <= 4'd0;
            literal_r   <= 16'd0;
        end else begin
            cmd_valid_r <= cmd_valid_r;
            command_r   <= command_r;
            literal_r   <= literal_r;
        end
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            halted_r  <= halted_r || (act_s == ACT_HALT);
            illegal_r <= illegal_r || (act_s == ACT_ILL);
        end
    end

`ifdef SEQ_JZ_EN
    // Remembers that the output stage was empty during the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q_r <= 1'b0;
        end else begin
            idle_q_r <= !cmd_valid_r;
        end
    end
`endif

    assign cmd_valid = cmd_valid_r;
    assign command   = command_r;
    assign literal   = literal_r;
    assign halted    = halted_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer.
// Uses a program table and an expected-command scoreboard.
// Also runs hand-written sequences for backpressure, JMP, HALT/illegal and opcode 8.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data;
    logic [3:0]  command;
    logic [15:0] literal;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        tos_zero;
    logic        halted;
    logic        illegal;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .command   (command),
        .literal   (literal),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .tos_zero  (tos_zero),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Synchronous instruction memory; garbage (undefined opcode) when not read.
    logic [19:0] mem [0:255];
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
        else         imem_data <= 20'hF0BAD;
    end

    typedef struct {
        logic [19:0] word;     // instruction placed in memory
        logic        fwd;      // expected to reach the output stage
        logic [3:0]  exp_cmd;
        logic [15:0] exp_lit;
    } vec_t;

    vec_t        prog [9];
    logic [19:0] sb_q [$];
    logic [19:0] exp_w;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en;
    bit          seen99;
    bit          rd_after_halt;
    int          cnt5;

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [15:0] v);
        return {op, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 20'hF0000;
    endtask

    // One cycle: set cmd_ready at the falling edge, then observe the DUT.
    task automatic tick(input logic rdy);
        @(negedge clk);
        cmd_ready = rdy;
        #1;
        if (!rst) begin
            if (!cmd_valid) check("idle_zero", {12'd0, command, literal}, 32'd0);
            if (halted && imem_rd) rd_after_halt = 1'b1;
            if (cmd_valid && literal == 16'd99) seen99 = 1'b1;
            if (cmd_valid && cmd_ready) begin
                if (command == 4'd1 && literal == 16'd5) cnt5++;
                if (mon_en) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_cmd: got %0h expected none", {command, literal});
                    end else begin
                        exp_w = sb_q.pop_front();
                        check("cmd_stream", {12'd0, command, literal}, {12'd0, exp_w});
                    end
                end
            end
        end
    endtask

    // Hold reset two cycles, check reset values, then release.
    task automatic do_reset();
        rst = 1'b1;
        mon_en = 1'b0;
        seen99 = 1'b0;
        rd_after_halt = 1'b0;
        cnt5 = 0;
        tick(1'b1);
        tick(1'b1);
        check("rst_imem_rd", imem_rd, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_command", command, 0);
        check("rst_literal", literal, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        cmd_ready = 1'b1;
        tos_zero = 1'b0;
        mon_en = 1'b0;

        prog[0] = '{ins(4'd1, 16'd11),    1'b1, 4'd1, 16'd11};
        prog[1] = '{ins(4'd1, 16'd13),    1'b1, 4'd1, 16'd13};
        prog[2] = '{ins(4'd2, 16'd0),     1'b1, 4'd2, 16'd0};
        prog[3] = '{ins(4'd1, 16'd7),     1'b1, 4'd1, 16'd7};
        prog[4] = '{ins(4'd1, 16'd2),     1'b1, 4'd1, 16'd2};
        prog[5] = '{ins(4'd4, 16'h00A5),  1'b1, 4'd4, 16'h00A5};
        prog[6] = '{ins(4'd3, 16'd0),     1'b1, 4'd3, 16'd0};
        prog[7] = '{ins(4'd5, 16'hBEEF),  1'b1, 4'd5, 16'hBEEF};
        prog[8] = '{ins(4'd7, 16'd0),     1'b0, 4'd0, 16'd0};

        // ---- straight line, full throughput ----
        fill_mem();
        sb_q.delete();
        for (int i = 0; i < 9; i++) begin
            mem[i] = prog[i].word;
            if (prog[i].fwd) sb_q.push_back({prog[i].exp_cmd, prog[i].exp_lit});
        end
        do_reset();
        #1;
        check("first_fetch_rd", imem_rd, 1);
        check("first_fetch_addr", imem_addr, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1);
            if (k < 3) check("latency_idle", cmd_valid, 0);
            else if (k <= 10) check("stream_valid", cmd_valid, 1);
        end
        check("line_drained", sb_q.size(), 0);
        check("line_halted", halted, 1);
        check("line_illegal", illegal, 0);

        // ---- backpressure on PUSH 13 ----
        sb_q.delete();
        for (int i = 0; i < 9; i++)
            if (prog[i].fwd) sb_q.push_back({prog[i].exp_cmd, prog[i].exp_lit});
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            check("bp_hold", {11'd0, cmd_valid, command, literal}, {11'd0, 1'b1, 4'd1, 16'd13});
        end
        check("bp_fetch_stop", imem_rd, 0);
        for (int k = 0; k < 14; k++) tick(1'b1);
        check("bp_drained", sb_q.size(), 0);

        // ---- JMP ----
        fill_mem();
        mem[0] = ins(4'd1, 16'd1);
        mem[1] = ins(4'd6, 16'd5);
        mem[2] = ins(4'd1, 16'd99);
        mem[5] = ins(4'd1, 16'd3);
        mem[6] = ins(4'd7, 16'd0);
        sb_q.delete();
        sb_q.push_back(ins(4'd1, 16'd1));
        sb_q.push_back(ins(4'd1, 16'd3));
        do_reset();
        for (int k = 0; k < 14; k++) tick(1'b1);
        check("jmp_drained", sb_q.size(), 0);
        check("jmp_no99", seen99, 0);
        check("jmp_illegal", illegal, 0);
        check("jmp_halted", halted, 1);

        // ---- HALT + illegal ----
        fill_mem();
        mem[0] = ins(4'd1, 16'd4);
        mem[1] = ins(4'd12, 16'd0);
        mem[2] = ins(4'd7, 16'd0);
        mem[3] = ins(4'd1, 16'd9);
        sb_q.delete();
        sb_q.push_back(ins(4'd1, 16'd4));
        do_reset();
        for (int k = 0; k < 16; k++) tick(1'b1);
        check("halt_drained", sb_q.size(), 0);
        check("halt_illegal", illegal, 1);
        check("halt_halted", halted, 1);
        check("halt_no_fetch", rd_after_halt, 0);
        check("halt_rd_low", imem_rd, 0);

        // ---- opcode 8 ----
        fill_mem();
        mem[0] = ins(4'd1, 16'd5);
        mem[1] = ins(4'd8, 16'd0);
        mem[2] = ins(4'd1, 16'd6);
        mem[3] = ins(4'd7, 16'd0);
`ifdef SEQ_JZ_EN
        tos_zero = 1'b0;
        sb_q.delete();
        sb_q.push_back(ins(4'd1, 16'd5));
        sb_q.push_back(ins(4'd1, 16'd6));
        do_reset();
        for (int k = 0; k < 20; k++) tick(1'b1);
        check("jz_fall_drained", sb_q.size(), 0);
        check("jz_fall_illegal", illegal, 0);
        check("jz_fall_halted", halted, 1);
        tos_zero = 1'b1;
        do_reset();
        mon_en = 1'b0;
        for (int k = 0; k < 40; k++) tick(1'b1);
        check("jz_loop_count", (cnt5 >= 3), 1);
        check("jz_loop_halted", halted, 0);
        tos_zero = 1'b0;
`else
        tos_zero = 1'b1;
        sb_q.delete();
        sb_q.push_back(ins(4'd1, 16'd5));
        sb_q.push_back(ins(4'd1, 16'd6));
        do_reset();
        for (int k = 0; k < 16; k++) tick(1'b1);
        check("op8_drained", sb_q.size(), 0);
        check("op8_illegal", illegal, 1);
        check("op8_halted", halted, 1);
        tos_zero = 1'b0;
`endif

        // Final reset clears sticky flags.
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
